// File: rtl/game_input.sv
// game_input: synchronises, debounces and edge-detects five player buttons and hands fixed-priority commands
// to the game controller over a valid/ready handshake. Define GAME_INPUT_REPEAT_EN to build LEFT/RIGHT/DOWN auto-repeat.
module game_input #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_rotate,
    input  logic       btn_drop,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic [4:0] held
);

    localparam int               DEB_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Bit order everywhere: {drop, rotate, down, right, left}
    logic [4:0] raw;
    logic [4:0] deb_level;
    logic [4:0] deb_d_reg;
    logic [4:0] rise;
    logic [4:0] tick;
    logic [4:0] pending_reg;
    logic [4:0] pending_next;
    logic [4:0] grant;
    logic [2:0] sel_code;
    logic       cmd_valid_reg;
    logic [2:0] cmd_reg;

    assign raw = {btn_drop, btn_rotate, btn_down, btn_right, btn_left};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    deb_reg     <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    // Any agreement restarts the stability count, so short glitches never land
                    if (sync2_reg == deb_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_reg     <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_level[gi] = deb_reg;
        end
    endgenerate

    assign rise = deb_level & ~deb_d_reg;

`ifdef GAME_INPUT_REPEAT_EN
    localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               REP_W     = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rep
            logic [REP_W-1:0] rep_cnt_reg;
            logic             rep_armed_reg;
            logic             hold_on;
            logic             rep_hit;

            // Counting starts the cycle the press is registered, so repeats line up with the press command
            assign hold_on = deb_level[gi] & deb_d_reg[gi];
            assign rep_hit = hold_on && (rep_cnt_reg == (rep_armed_reg ? REP_NEXT : REP_FIRST));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rep_cnt_reg   <= '0;
                    rep_armed_reg <= 1'b0;
                end else if (!hold_on) begin
                    rep_cnt_reg   <= '0;
                    rep_armed_reg <= 1'b0;
                end else if (rep_hit) begin
                    rep_cnt_reg   <= '0;
                    rep_armed_reg <= 1'b1;
                end else begin
                    rep_cnt_reg <= rep_cnt_reg + 1'b1;
                end
            end

            assign tick[gi] = rep_hit;
        end
    endgenerate

    assign tick[4:3] = 2'b00;
`else
    // Repeat timing is irrelevant in this build; the block only marks the parameters as consumed
    if (REPEAT_DELAY < 0 && REPEAT_PERIOD < 0) begin : g_repeat_unused
    end

    assign tick = '0;
`endif

    always_comb begin
        sel_code = 3'd0;
        grant    = 5'b00000;
        if (!cmd_valid_reg) begin
            if (pending_reg[4]) begin
                sel_code = 3'd5;
                grant    = 5'b10000;
            end else if (pending_reg[3]) begin
                sel_code = 3'd4;
                grant    = 5'b01000;
            end else if (pending_reg[0]) begin
                sel_code = 3'd1;
                grant    = 5'b00001;
            end else if (pending_reg[1]) begin
                sel_code = 3'd2;
                grant    = 5'b00010;
            end else if (pending_reg[2]) begin
                sel_code = 3'd3;
                grant    = 5'b00100;
            end
        end
        // New events win over the grant clear so nothing arriving this cycle is dropped
        pending_next = (pending_reg & ~grant) | rise | tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_d_reg     <= '0;
            pending_reg   <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_reg       <= 3'd0;
        end else begin
            deb_d_reg   <= deb_level;
            pending_reg <= pending_next;
            if (cmd_valid_reg) begin
                if (cmd_ready) begin
                    cmd_valid_reg <= 1'b0;
                    cmd_reg       <= 3'd0;
                end
            end else if (|grant) begin
                cmd_valid_reg <= 1'b1;
                cmd_reg       <= sel_code;
            end
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd       = cmd_reg;
    assign held      = deb_level;

endmodule

// File: tb/tb_game_input.sv
// Scoreboard bench for game_input: expected commands are queued with the stimulus and popped on each handshake.
`timescale 1ns/1ps
module tb_game_input;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_rotate = 1'b0;
    logic       btn_drop = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [4:0] held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];
    int acc_cyc[$];
    bit prev_acc = 1'b0;

    game_input #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .btn_rotate(btn_rotate),
        .btn_drop  (btn_drop),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .held      (held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: pops the scoreboard and checks the idle cycle after each acceptance
    always @(negedge clk) begin
        if (!rst) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) begin
                total++;
                if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
                    bad++;
                    $display("FAIL gap: cmd_valid=%0b cmd=%0d required valid=0 cmd=0", cmd_valid, cmd);
                end
            end
            prev_acc = 1'b0;
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                int e;
                prev_acc = 1'b1;
                acc_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cmd: got cmd=%0d required none at cyc=%0d", cmd, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn cmd=%0d expected=%0d cyc=%0d", cmd, e, cyc);
                    if (cmd !== 3'(e)) begin
                        bad++;
                        $display("FAIL cmd_order: got %0d required %0d", cmd, e);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
        step(4);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: outstanding=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        total++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0 || held !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%0b cmd=%0d held=%b required 0/0/00000", cmd_valid, cmd, held);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        step(20);
        // Mid-operation reset with a command held under backpressure
        cmd_ready = 1'b0;
        btn_drop  = 1'b1;
        wait_valid(20, ok);
        total++;
        if (!ok || cmd !== 3'd5) begin
            bad++;
            $display("FAIL reset_precond: valid=%0b cmd=%0d required valid=1 cmd=5", cmd_valid, cmd);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0 || held !== 5'd0) begin
            bad++;
            $display("FAIL reset_mid: valid=%0b cmd=%0d held=%b required 0/0/00000", cmd_valid, cmd, held);
        end
        btn_drop = 1'b0;
        step(3);
        rst       = 1'b1;
        cmd_ready = 1'b1;
        step(30);
        total++;
        if (cmd_valid !== 1'b0 || acc_cyc.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: valid=%0b accepts=%0d required 0/0", cmd_valid, acc_cyc.size());
        end
    endtask

    task automatic test_bounce();
        int  t_edge0;
        int  held_cyc  = -1;
        int  valid_cyc = -1;
        bit  early     = 1'b0;
        acc_cyc.delete();
        exp_q.push_back(4);
        for (int i = 0; i < 10; i++) begin
            btn_rotate = ~btn_rotate;
            for (int k = 0; k < 2; k++) begin
                step(1);
                if (held[3] === 1'b1) early = 1'b1;
            end
        end
        btn_rotate = 1'b1;
        t_edge0 = cyc + 1;
        total++;
        if (early) begin
            bad++;
            $display("FAIL bounce_glitch: held[3] rose during bounce, required stay 0");
        end
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (held[3] === 1'b1) begin
                held_cyc = cyc;
                break;
            end
        end
        total++;
        if (held_cyc - t_edge0 != DEB + 1) begin
            bad++;
            $display("FAIL bounce_held_edge: edge=%0d required %0d", held_cyc - t_edge0, DEB + 1);
        end
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid === 1'b1) begin
                valid_cyc = cyc;
                break;
            end
            step(1);
        end
        total++;
        if (valid_cyc - t_edge0 != DEB + 3) begin
            bad++;
            $display("FAIL bounce_valid_edge: edge=%0d required %0d", valid_cyc - t_edge0, DEB + 3);
        end
        btn_rotate = 1'b0;
        step(DEB + 8);
        drain("bounce", 20);
        total++;
        if (acc_cyc.size() != 1) begin
            bad++;
            $display("FAIL bounce_count: accepts=%0d required 1", acc_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        acc_cyc.delete();
        cmd_ready = 1'b0;
        exp_q.push_back(5);
        exp_q.push_back(4);
        exp_q.push_back(1);
        btn_drop   = 1'b1;
        step(2);
        btn_rotate = 1'b1;
        step(2);
        btn_left   = 1'b1;
        step(12);
        btn_drop   = 1'b0;
        btn_rotate = 1'b0;
        btn_left   = 1'b0;
        wait_valid(10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_timeout: cmd_valid=%0b required 1", cmd_valid);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++;
            if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin
                bad++;
                $display("FAIL bp_hold: cyc=%0d valid=%0b cmd=%0d required 1/5", cyc, cmd_valid, cmd);
            end
        end
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        drain("bp", 30);
        total++;
        if (acc_cyc.size() != 3) begin
            bad++;
            $display("FAIL bp_count: accepts=%0d required 3", acc_cyc.size());
        end else begin
            total++;
            if (acc_cyc[1] - acc_cyc[0] != 2 || acc_cyc[2] - acc_cyc[1] != 2) begin
                bad++;
                $display("FAIL bp_spacing: gaps=%0d,%0d required 2,2", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    task automatic test_repeat();
        int n;
`ifdef GAME_INPUT_REPEAT_EN
        int offs[5] = '{20, 28, 36, 44, 52};
        n = 6;
`else
        n = 1;
`endif
        acc_cyc.delete();
        cmd_ready = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(1);
        btn_left = 1'b1;
        step(57);
        btn_left = 1'b0;
        drain("repeat", 120);
        step(30);
        total++;
        if (acc_cyc.size() != n) begin
            bad++;
            $display("FAIL repeat_count: accepts=%0d required %0d", acc_cyc.size(), n);
        end
`ifdef GAME_INPUT_REPEAT_EN
        else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (acc_cyc[i+1] - acc_cyc[0] != offs[i]) begin
                    bad++;
                    $display("FAIL repeat_time_%0d: offset=%0d required %0d", i, acc_cyc[i+1] - acc_cyc[0], offs[i]);
                end
            end
        end
`endif
    endtask

    task automatic test_simultaneous();
        bit ok;
        acc_cyc.delete();
        cmd_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(2);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        wait_valid(20, ok);
        total++;
        if (!ok || cmd !== 3'd1) begin
            bad++;
            $display("FAIL simul_first: valid=%0b cmd=%0d required 1/1", cmd_valid, cmd);
        end
        @(posedge clk); #1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        step(DEB + 6);
        total++;
        if (held !== 5'd0) begin
            bad++;
            $display("FAIL simul_release: held=%b required 00000", held);
        end
        cmd_ready = 1'b1;
        drain("simul", 20);
        total++;
        if (acc_cyc.size() != 2) begin
            bad++;
            $display("FAIL simul_count: accepts=%0d required 2", acc_cyc.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_bounce();
        test_backpressure();
        test_repeat();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
